// File: rtl/seg_pkg.sv
// Shared constants for the active-low 7-segment capture path: digit patterns,
// blank/invalid codes and the capture FSM state encoding.
package seg_pkg;

    // Patterns are listed a..g, bit 6 = a, active-low (0 = lit).
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0001100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK   = 4'hE;
    localparam logic [3:0] CODE_INVALID = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_RELEASE
    } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Active-low 7-segment pattern to BCD code; blank gives CODE_BLANK, anything
// unrecognised gives CODE_INVALID with err_o set.
// Purely combinational, no flow control.
module seg7_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] seg_n_i,
    output logic [3:0] code_o,
    output logic       err_o
);

    always_comb begin
        code_o = CODE_INVALID;
        err_o  = 1'b1;
        case (seg_n_i)
            SEG_0:     begin code_o = 4'd0;       err_o = 1'b0; end
            SEG_1:     begin code_o = 4'd1;       err_o = 1'b0; end
            SEG_2:     begin code_o = 4'd2;       err_o = 1'b0; end
            SEG_3:     begin code_o = 4'd3;       err_o = 1'b0; end
            SEG_4:     begin code_o = 4'd4;       err_o = 1'b0; end
            SEG_5:     begin code_o = 4'd5;       err_o = 1'b0; end
            SEG_6:     begin code_o = 4'd6;       err_o = 1'b0; end
            SEG_7:     begin code_o = 4'd7;       err_o = 1'b0; end
            SEG_8:     begin code_o = 4'd8;       err_o = 1'b0; end
            SEG_9:     begin code_o = 4'd9;       err_o = 1'b0; end
            SEG_BLANK: begin code_o = CODE_BLANK; err_o = 1'b0; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Recovers BCD digits from a multiplexed active-low 7-seg bus into coherent frames.
// Latency: pad strobe to sample 3+SETTLE cycles; frame_valid 2 cycles after final sample.
// No backpressure; optional SEG_SCAN_CAPTURE_CONFIRM_EN requires two matching frames per digit.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SETTLE   = 8,
    parameter int TIMEOUT  = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg_n,
    input  logic [N_DIGITS-1:0]   dig_n,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [N_DIGITS-1:0]   digit_err,
    output logic                  frame_valid,
    output logic                  stale
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

    logic [6:0]            seg_s1_q, seg_s2_q;
    logic [N_DIGITS-1:0]   dig_s1_q, dig_s2_q;
    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d, strb_idx;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [N_DIGITS-1:0]   mask_q, mask_d;
    logic [4*N_DIGITS-1:0] stage_q, stage_d, digits_q, digits_d;
    logic [N_DIGITS-1:0]   stage_err_q, stage_err_d, err_q, err_d;
    logic                  fv_q, stale_q, stale_d;
    logic [3:0]            low_cnt, dec_code;
    logic                  strb_vld, strb_same, dec_err, commit;

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_s1_q <= SEG_BLANK;
            seg_s2_q <= SEG_BLANK;
            dig_s1_q <= '1;
            dig_s2_q <= '1;
        end else begin
            seg_s1_q <= seg_n;
            seg_s2_q <= seg_s1_q;
            dig_s1_q <= dig_n;
            dig_s2_q <= dig_s1_q;
        end
    end

    // Zero-hot and multi-hot strobes both count as "no strobe".
    always_comb begin
        strb_idx = '0;
        low_cnt  = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!dig_s2_q[i]) begin
                strb_idx = IDX_W'(i);
                low_cnt  = low_cnt + 4'd1;
            end
        end
    end

    assign strb_vld  = (low_cnt == 4'd1);
    assign strb_same = strb_vld && (strb_idx == idx_q);
    assign commit    = &mask_q;

    seg7_to_bcd u_dec (
        .seg_n_i (seg_s2_q),
        .code_o  (dec_code),
        .err_o   (dec_err)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        stage_err_d = stage_err_q;
        mask_d      = commit ? '0 : mask_q;
        unique case (state_q)
            ST_IDLE: begin
                if (strb_vld) begin
                    idx_d   = strb_idx;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!strb_same)            state_d = ST_IDLE;
                else if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
                else                        cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_SAMPLE: begin
                stage_d[{idx_q, 2'b00} +: 4] = dec_code;
                stage_err_d[idx_q]           = dec_err;
                mask_d[idx_q]                = 1'b1;
                state_d                      = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!strb_same) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A commit in the same cycle as timeout expiry leaves stale clear.
    always_comb begin
        tmo_d = tmo_q;
        if (strb_vld)              tmo_d = '0;
        else if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_W'(1);
        stale_d = stale_q;
        if (commit)                stale_d = 1'b0;
        else if (tmo_d == TMO_MAX) stale_d = 1'b1;
    end

`ifdef SEG_SCAN_CAPTURE_CONFIRM_EN
    logic [4*N_DIGITS-1:0] prev_q;
    logic [N_DIGITS-1:0]   prev_err_q;

    always_comb begin
        digits_d = digits_q;
        err_d    = err_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (stage_q[i*4 +: 4] == prev_q[i*4 +: 4] && stage_err_q[i] == prev_err_q[i]) begin
                digits_d[i*4 +: 4] = stage_q[i*4 +: 4];
                err_d[i]           = stage_err_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= {N_DIGITS{CODE_BLANK}};
            prev_err_q <= '0;
        end else if (commit) begin
            prev_q     <= stage_q;
            prev_err_q <= stage_err_q;
        end
    end
`else
    assign digits_d = stage_q;
    assign err_d    = stage_err_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            mask_q      <= '0;
            stage_q     <= '0;
            stage_err_q <= '0;
            digits_q    <= {N_DIGITS{CODE_BLANK}};
            err_q       <= '0;
            fv_q        <= 1'b0;
            stale_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            mask_q      <= mask_d;
            stage_q     <= stage_d;
            stage_err_q <= stage_err_d;
            fv_q        <= commit;
            stale_q     <= stale_d;
            if (commit) begin
                digits_q <= digits_d;
                err_q    <= err_d;
            end
        end
    end

    assign digits      = digits_q;
    assign digit_err   = err_q;
    assign frame_valid = fv_q;
    assign stale       = stale_q;

endmodule
